multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; forces state BOOT and clears internal registers immediately.
REQ-003 instr  input  32  current instruction-register contents; sampled for decode in DECODE, EXEC, MEM and WB.
REQ-004 mem_ready  input  1  memory completion handshake for instruction and data accesses.
REQ-005 alu_zero, alu_neg, alu_ovf  input  1 each  ALU result flags from the current cycle.
REQ-006 imem_req, dmem_read, dmem_write  output  1 each  memory request strobes.
REQ-007 ir_write, pc_write, reg_write, flag_write  output  1 each  register enables.
REQ-008 pc_src  output  1  0 = PC+4, 1 = PC + (extended immediate << 2).
REQ-009 alu_src  output  1  0 = register operand B, 1 = extended immediate.
REQ-010 mem_to_reg  output  1  write-back source: 1 = load data.
REQ-011 alu_op  output  2  00 add, 01 sub, 10 pass operand B.
REQ-012 ext_sel  output  3  immediate format for the extender: 0 none, 1 R-shamt, 2 D, 3 CB, 4 B, 5 I.
REQ-013 illegal  output  1  one-cycle pulse in DECODE when the opcode is unrecognised.
REQ-014 state  output  3  current state: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.

Function
REQ-015 Decode classes: ADDS instr[31:21]=10101011000; SUBS 11101011000; LDUR 11111000010; STUR 11111000000; ADDI instr[31:22]=1001000100; B instr[31:26]=000101; CBZ instr[31:24]=10110100; B.LT instr[31:24]=01010100 with instr[4:0]=01011.
REQ-016 Every output is a combinational function of state, decoded class, mem_ready and the latched flags; any output not specified for a state is 0.
REQ-017 BOOT: all outputs 0; next state FETCH unconditionally.
REQ-018 FETCH: imem_req=1; if mem_ready=0, remain in FETCH; if mem_ready=1, ir_write=1, pc_write=1, pc_src=0, and next state DECODE.
REQ-019 DECODE: ext_sel is driven per class (ADDS/SUBS 1, LDUR/STUR 2, CBZ/B.LT 3, B 4, ADDI 5); next state EXEC; an unrecognised opcode pulses illegal=1 and goes to FETCH.
REQ-020 ext_sel holds its DECODE value through EXEC, MEM and WB of the same instruction.
REQ-021 EXEC ADDS/SUBS: alu_src=0, alu_op=00/01, flag_write=1; next state WB.
REQ-022 EXEC ADDI: alu_src=1, alu_op=00; next state WB.
REQ-023 EXEC LDUR/STUR: alu_src=1, alu_op=00; next state MEM.
REQ-024 EXEC B: pc_write=1, pc_src=1; next state FETCH.
REQ-025 EXEC CBZ: alu_src=0, alu_op=10; pc_write=pc_src=alu_zero; next state FETCH.
REQ-026 EXEC B.LT: taken when latched N != latched V; pc_write=pc_src=taken; next state FETCH.
REQ-027 Flags N and V are captured from alu_neg and alu_ovf on the clock edge where flag_write=1 and are otherwise held; a B.LT immediately after an ADDS/SUBS sees the updated flags.
REQ-028 MEM LDUR: dmem_read=1 until mem_ready=1, then next state WB; MEM STUR: dmem_write=1 until mem_ready=1, then next state FETCH.
REQ-029 MEM stalls indefinitely while mem_ready=0, with strobes held constant.
REQ-030 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 only for LDUR; next state FETCH.
REQ-031 mem_ready is ignored in BOOT, DECODE, EXEC and WB.
REQ-032 Cycle counts with zero-wait memory: R/I 4, LDUR 5, STUR 4, branch 3.

Reset
REQ-033 While reset=1, state=BOOT, latched N=V=0, and all outputs are 0.
REQ-034 When reset is asserted mid-instruction (including a MEM stall), the access is abandoned and no reg_write, pc_write or flag_write occurs.
REQ-035 After reset deasserts, the first FETCH occurs one clock later.

Verification
REQ-036 Release reset with mem_ready=1 and ADDI 0x91000421: state sequence 0,1,2,3,5,1; ext_sel=5; reg_write pulses once.
REQ-037 LDUR with mem_ready low for 3 MEM cycles: dmem_read held for 4 cycles; WB has mem_to_reg=1.
REQ-038 SUBS with alu_neg=1, alu_ovf=0, then B.LT: pc_write=pc_src=1 in the B.LT EXEC cycle; repeat with alu_neg=alu_ovf=1: no pc_write.
REQ-039 CBZ with alu_zero=0: pc_write=0 and return to FETCH; with alu_zero=1: pc_src=1.
REQ-040 Opcode 0x00000000: illegal pulses in DECODE and the next state is FETCH.
REQ-041 Assert reset during a STUR MEM stall: dmem_write drops immediately, state=0, and no write strobes occur afterward.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle ARM-style datapath. It decodes the instruction register,
// sequences fetch/decode/execute/memory/write-back and drives the datapath enables.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    output logic        imem_req,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        flag_write,
    output logic        pc_src,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic [2:0]  ext_sel,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE = 4'd0,
        C_ADDS = 4'd1,
        C_SUBS = 4'd2,
        C_LDUR = 4'd3,
        C_STUR = 4'd4,
        C_ADDI = 4'd5,
        C_B    = 4'd6,
        C_CBZ  = 4'd7,
        C_BLT  = 4'd8
    } class_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

    state_t state_q;
    class_t class_q;
    logic   n_q;
    logic   v_q;
    class_t dec_class;
    logic   blt_taken;
    logic   unused_instr_bits;

    assign unused_instr_bits = ^instr[20:5];

    always_comb begin
        dec_class = C_NONE;
        if (instr[31:21] == 11'b10101011000) begin
            dec_class = C_ADDS;
        end else if (instr[31:21] == 11'b11101011000) begin
            dec_class = C_SUBS;
        end else if (instr[31:21] == 11'b11111000010) begin
            dec_class = C_LDUR;
        end else if (instr[31:21] == 11'b11111000000) begin
            dec_class = C_STUR;
        end else if (instr[31:22] == 10'b1001000100) begin
            dec_class = C_ADDI;
        end else if (instr[31:26] == 6'b000101) begin
            dec_class = C_B;
        end else if (instr[31:24] == 8'b10110100) begin
            dec_class = C_CBZ;
        end else if (instr[31:24] == 8'b01010100 && instr[4:0] == 5'b01011) begin
            dec_class = C_BLT;
        end
    end

    function automatic logic [2:0] ext_of(input class_t c);
        case (c)
            C_ADDS, C_SUBS: ext_of = 3'd1;
            C_LDUR, C_STUR: ext_of = 3'd2;
            C_CBZ, C_BLT:   ext_of = 3'd3;
            C_B:            ext_of = 3'd4;
            C_ADDI:         ext_of = 3'd5;
            default:        ext_of = 3'd0;
        endcase
    endfunction

    // Signed less-than uses the flags latched by the most recent ADDS/SUBS.
    assign blt_taken = n_q ^ v_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
            class_q <= C_NONE;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            if (flag_write) begin
                n_q <= alu_neg;
                v_q <= alu_ovf;
            end
            case (state_q)
                S_BOOT: state_q <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    class_q <= dec_class;
                    state_q <= (dec_class == C_NONE) ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    case (class_q)
                        C_ADDS, C_SUBS, C_ADDI: state_q <= S_WB;
                        C_LDUR, C_STUR:         state_q <= S_MEM;
                        default:                state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_q <= (class_q == C_LDUR) ? S_WB : S_FETCH;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_BOOT;
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        flag_write = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        ext_sel    = 3'd0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                ext_sel = ext_of(dec_class);
                illegal = (dec_class == C_NONE);
            end
            S_EXEC: begin
                ext_sel = ext_of(class_q);
                case (class_q)
                    C_ADDS: flag_write = 1'b1;
                    C_SUBS: begin
                        alu_op     = ALU_SUB;
                        flag_write = 1'b1;
                    end
                    C_ADDI, C_LDUR, C_STUR: alu_src = 1'b1;
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    C_CBZ: begin
                        alu_op   = ALU_PASS;
                        pc_write = alu_zero;
                        pc_src   = alu_zero;
                    end
                    C_BLT: begin
                        pc_write = blt_taken;
                        pc_src   = blt_taken;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ext_sel    = ext_of(class_q);
                dmem_read  = (class_q == C_LDUR);
                dmem_write = (class_q == C_STUR);
            end
            S_WB: begin
                ext_sel    = ext_of(class_q);
                reg_write  = 1'b1;
                mem_to_reg = (class_q == C_LDUR);
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected output vectors are queued with the
// stimulus that produces them and compared at the falling edge.
module tb_multicycle_control;

    localparam int W = 19;

    localparam logic [9:0] IMEM = 10'b1000000000;
    localparam logic [9:0] DRD  = 10'b0100000000;
    localparam logic [9:0] DWR  = 10'b0010000000;
    localparam logic [9:0] IRW  = 10'b0001000000;
    localparam logic [9:0] PCW  = 10'b0000100000;
    localparam logic [9:0] RGW  = 10'b0000010000;
    localparam logic [9:0] FLW  = 10'b0000001000;
    localparam logic [9:0] PCS  = 10'b0000000100;
    localparam logic [9:0] ASRC = 10'b0000000010;
    localparam logic [9:0] M2R  = 10'b0000000001;

    localparam int K_ADDS = 0;
    localparam int K_SUBS = 1;
    localparam int K_ADDI = 2;
    localparam int K_LDUR = 3;
    localparam int K_STUR = 4;
    localparam int K_B    = 5;
    localparam int K_CBZ  = 6;
    localparam int K_BLT  = 7;
    localparam int K_ILL  = 8;

    typedef struct packed {
        logic [31:0] ins;
        logic        mr;
        logic        z;
        logic        n;
        logic        v;
    } stim_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_ovf;
    logic        imem_req;
    logic        dmem_read;
    logic        dmem_write;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        flag_write;
    logic        pc_src;
    logic        alu_src;
    logic        mem_to_reg;
    logic [1:0]  alu_op;
    logic [2:0]  ext_sel;
    logic        illegal;
    logic [2:0]  state;

    logic [W-1:0] obs;
    logic [W-1:0] exp_q[$];
    stim_t        stim_q[$];
    int           vectors;
    int           miscompares;
    int           cyc;
    logic         m_n;
    logic         m_v;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .alu_ovf    (alu_ovf),
        .imem_req   (imem_req),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .flag_write (flag_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .ext_sel    (ext_sel),
        .illegal    (illegal),
        .state      (state)
    );

    assign obs = {state, imem_req, dmem_read, dmem_write, ir_write, pc_write, reg_write,
                  flag_write, pc_src, alu_src, mem_to_reg, alu_op, ext_sel, illegal};

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] ev(input logic [2:0] st, input logic [9:0] f,
                                        input logic [1:0] aop, input logic [2:0] ext,
                                        input logic ill);
        return {st, f, aop, ext, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [31:0] ins, input logic mr, input logic z,
                        input logic n, input logic v, input logic [W-1:0] e);
        stim_t s;
        s = '{ins: ins, mr: mr, z: z, n: n, v: v};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Queues one whole instruction: stimulus per cycle and the outputs each cycle must show.
    task automatic push_instr(input int kind, input int fw, input int mw,
                              input logic z, input logic n, input logic v);
        logic [31:0] ins;
        logic [2:0]  ext;
        logic        taken;
        case (kind)
            K_ADDS:  begin ins = 32'hAB020020; ext = 3'd1; end
            K_SUBS:  begin ins = 32'hEB030041; ext = 3'd1; end
            K_ADDI:  begin ins = 32'h91000421; ext = 3'd5; end
            K_LDUR:  begin ins = 32'hF8408041; ext = 3'd2; end
            K_STUR:  begin ins = 32'hF8008062; ext = 3'd2; end
            K_B:     begin ins = 32'h14000010; ext = 3'd4; end
            K_CBZ:   begin ins = 32'hB4000083; ext = 3'd3; end
            K_BLT:   begin ins = 32'h5400004B; ext = 3'd3; end
            default: begin ins = 32'h00000000; ext = 3'd0; end
        endcase
        for (int i = 0; i < fw; i++) push(ins, 1'b0, rb(), rb(), rb(), ev(3'd1, IMEM, 2'b00, 3'd0, 1'b0));
        push(ins, 1'b1, rb(), rb(), rb(), ev(3'd1, IMEM | IRW | PCW, 2'b00, 3'd0, 1'b0));
        push(ins, rb(), rb(), rb(), rb(), ev(3'd2, 10'd0, 2'b00, ext, kind == K_ILL));
        case (kind)
            K_ADDS, K_SUBS: begin
                push(ins, rb(), rb(), n, v, ev(3'd3, FLW, (kind == K_SUBS) ? 2'b01 : 2'b00, ext, 1'b0));
                m_n = n;
                m_v = v;
                push(ins, rb(), rb(), rb(), rb(), ev(3'd5, RGW, 2'b00, ext, 1'b0));
            end
            K_ADDI: begin
                push(ins, rb(), rb(), rb(), rb(), ev(3'd3, ASRC, 2'b00, ext, 1'b0));
                push(ins, rb(), rb(), rb(), rb(), ev(3'd5, RGW, 2'b00, ext, 1'b0));
            end
            K_LDUR, K_STUR: begin
                push(ins, rb(), rb(), rb(), rb(), ev(3'd3, ASRC, 2'b00, ext, 1'b0));
                for (int i = 0; i < mw; i++)
                    push(ins, 1'b0, rb(), rb(), rb(), ev(3'd4, (kind == K_LDUR) ? DRD : DWR, 2'b00, ext, 1'b0));
                push(ins, 1'b1, rb(), rb(), rb(), ev(3'd4, (kind == K_LDUR) ? DRD : DWR, 2'b00, ext, 1'b0));
                if (kind == K_LDUR) push(ins, rb(), rb(), rb(), rb(), ev(3'd5, RGW | M2R, 2'b00, ext, 1'b0));
            end
            K_B: push(ins, rb(), rb(), rb(), rb(), ev(3'd3, PCW | PCS, 2'b00, ext, 1'b0));
            K_CBZ: push(ins, rb(), z, rb(), rb(), ev(3'd3, z ? (PCW | PCS) : 10'd0, 2'b10, ext, 1'b0));
            K_BLT: begin
                taken = (m_n != m_v);
                push(ins, rb(), rb(), rb(), rb(), ev(3'd3, taken ? (PCW | PCS) : 10'd0, 2'b00, ext, 1'b0));
            end
            default: ;
        endcase
    endtask

    // Driver: applies the next queued stimulus and returns the expected vector at the falling edge.
    task automatic apply_next(output logic [W-1:0] e);
        stim_t s;
        s = stim_q.pop_front();
        instr     = s.ins;
        mem_ready = s.mr;
        alu_zero  = s.z;
        alu_neg   = s.n;
        alu_ovf   = s.v;
        @(negedge clk);
        e = exp_q.pop_front();
        cyc++;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = rb();
            instr     = $urandom;
            @(negedge clk);
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: observed %h expected %h", i, obs, {W{1'b0}});
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        m_n = 1'b0;
        m_v = 1'b0;
    endtask

    task automatic test_addi();
        logic [W-1:0] e;
        push(32'h91000421, 1'b1, rb(), rb(), rb(), ev(3'd0, 10'd0, 2'b00, 3'd0, 1'b0));
        push_instr(K_ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL addi cycle %0d: observed %h expected %h", cyc, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_store();
        logic [W-1:0] e;
        push_instr(K_LDUR, 0, 3, 1'b0, 1'b0, 1'b0);
        push_instr(K_LDUR, 2, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_STUR, 0, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_STUR, 1, 2, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL load_store cycle %0d: observed %h expected %h", cyc, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flags_blt();
        logic [W-1:0] e;
        push_instr(K_SUBS, 0, 0, 1'b0, 1'b1, 1'b0);
        push_instr(K_BLT, 0, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_SUBS, 0, 0, 1'b0, 1'b1, 1'b1);
        push_instr(K_BLT, 0, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_ADDS, 1, 0, 1'b0, 1'b0, 1'b1);
        push_instr(K_BLT, 0, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_BLT, 0, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_ADDS, 0, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_BLT, 0, 0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL flags_blt cycle %0d: observed %h expected %h", cyc, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branches();
        logic [W-1:0] e;
        push_instr(K_CBZ, 0, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_CBZ, 0, 0, 1'b1, 1'b0, 1'b0);
        push_instr(K_B, 1, 0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL branches cycle %0d: observed %h expected %h", cyc, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] e;
        push_instr(K_ILL, 0, 0, 1'b0, 1'b0, 1'b0);
        push(32'h5400000A, 1'b1, rb(), rb(), rb(), ev(3'd1, IMEM | IRW | PCW, 2'b00, 3'd0, 1'b0));
        push(32'h5400000A, rb(), rb(), rb(), rb(), ev(3'd2, 10'd0, 2'b00, 3'd0, 1'b1));
        push_instr(K_ADDI, 0, 0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL illegal cycle %0d: observed %h expected %h", cyc, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        for (int i = 0; i < 14; i++)
            push_instr($urandom_range(0, 8), $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb(), rb());
        while (exp_q.size() != 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: observed %h expected %h", cyc, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reset lands in a STUR memory stall after SUBS left N=1, V=0.
    task automatic test_reset_mid_stall();
        logic [W-1:0] e;
        push_instr(K_SUBS, 0, 0, 1'b0, 1'b1, 1'b0);
        push(32'hF8008062, 1'b1, rb(), rb(), rb(), ev(3'd1, IMEM | IRW | PCW, 2'b00, 3'd0, 1'b0));
        push(32'hF8008062, rb(), rb(), rb(), rb(), ev(3'd2, 10'd0, 2'b00, 3'd2, 1'b0));
        push(32'hF8008062, rb(), rb(), rb(), rb(), ev(3'd3, ASRC, 2'b00, 3'd2, 1'b0));
        push(32'hF8008062, 1'b0, rb(), rb(), rb(), ev(3'd4, DWR, 2'b00, 3'd2, 1'b0));
        push(32'hF8008062, 1'b0, rb(), rb(), rb(), ev(3'd4, DWR, 2'b00, 3'd2, 1'b0));
        while (exp_q.size() != 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL stall_setup cycle %0d: observed %h expected %h", cyc, obs, e);
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_abort: observed %h expected %h", obs, {W{1'b0}});
        end
        m_n = 1'b0;
        m_v = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            mem_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL reset_abort_hold cycle %0d: observed %h expected %h", i, obs, {W{1'b0}});
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(32'h5400004B, 1'b1, rb(), rb(), rb(), ev(3'd0, 10'd0, 2'b00, 3'd0, 1'b0));
        push_instr(K_BLT, 0, 0, 1'b0, 1'b0, 1'b0);
        push_instr(K_ADDI, 1, 0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            apply_next(e);
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL after_reset cycle %0d: observed %h expected %h", cyc, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        instr       = '0;
        mem_ready   = 1'b0;
        alu_zero    = 1'b0;
        alu_neg     = 1'b0;
        alu_ovf     = 1'b0;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        m_n         = 1'b0;
        m_v         = 1'b0;
        test_reset();
        test_addi();
        test_load_store();
        test_flags_blt();
        test_branches();
        test_illegal();
        test_back_to_back();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
